nios_ram_arbiter: RTL and testbench
===================================

NIOS_RAM_ARBITER -- requirements
Module: nios_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11: word address width for masters and RAM port.
REQ-002 Parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1: single clock for all logic.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 m0_address, m1_address  in  ADDR_W: master word address.
REQ-006 m0_read, m1_read  in  1: read request.
REQ-007 m0_write, m1_write  in  1: write request.
REQ-008 m0_byteenable, m1_byteenable  in  DATA_W/8: write byte lanes.
REQ-009 m0_writedata, m1_writedata  in  DATA_W: write data.
REQ-010 m0_waitrequest, m1_waitrequest  out  1: high means the request is not accepted this cycle.
REQ-011 m0_readdata, m1_readdata  out  DATA_W: read data.
REQ-012 m0_readdatavalid, m1_readdatavalid  out  1: readdata qualifier, one cycle wide.
REQ-013 ram_address  out  ADDR_W; ram_byteenable  out  DATA_W/8; ram_writedata  out  DATA_W.
REQ-014 ram_chipselect, ram_write, ram_clken  out  1: RAM port controls.
REQ-015 ram_readdata  in  DATA_W: RAM output, valid one cycle after an accepted address.

Function
REQ-016 A master requests when its read or write is high; read and write together from one master is illegal and SHALL be treated as a write.
REQ-017 At most one master is granted per cycle; the grant is combinational from current requests plus the last_grant register.
REQ-018 One requester: that master is granted.
REQ-019 Both requesting: the master not equal to last_grant is granted (round-robin).
REQ-020 last_grant updates on the clk edge of every granted cycle; it holds when nothing is granted.
REQ-021 Granted master: waitrequest=0; the other master, if requesting: waitrequest=1; a non-requesting master: waitrequest=0.
REQ-022 Granted cycle: ram_address/byteenable/writedata come from the granted master, ram_chipselect=1, ram_write equals its write.
REQ-023 Granted read: ram_byteenable is forced to all ones.
REQ-024 No grant: ram_chipselect=0, ram_write=0, ram_address holds its last granted value.
REQ-025 ram_clken SHALL be 1 except during reset.
REQ-026 Read accepted in cycle N: a registered tag (valid, owner) produces owner readdatavalid=1 in cycle N+1 with readdata=ram_readdata; fixed latency 1.
REQ-027 m0_readdata and m1_readdata both carry ram_readdata; only readdatavalid distinguishes the owner.
REQ-028 Back-to-back reads, including alternating owners, SHALL sustain one read per cycle with no bubble.
REQ-029 Writes produce no readdatavalid.
REQ-030 Starvation bound: a continuously requesting master SHALL be granted within 2 cycles.

Reset
REQ-031 On reset assertion, asynchronously: last_grant=1 (m0 wins the first contention), read tag valid=0, both readdatavalid=0, ram_clken=0.
REQ-032 A read accepted in the cycle reset asserts SHALL produce no readdatavalid.
REQ-033 During reset, ram_chipselect=0, ram_write=0, both waitrequest=1.
REQ-034 The first clk edge after reset deassertion SHALL be able to accept a request.

Verification
REQ-035 Reset release, then m0_write addr 0x005 data 0xDEADBEEF be 0xF, then m0_read 0x005 -> waitrequest 0 both cycles; m0_readdatavalid=1 one cycle after the read with 0xDEADBEEF.
REQ-036 After reset, both masters read simultaneously for 4 cycles -> grants m0,m1,m0,m1; each readdatavalid follows its grant by exactly 1 cycle.
REQ-037 m1_write be 0x3 data 0x12345678 over 0xFFFFFFFF at addr 0x7FF -> read back 0xFFFF5678 (address wrap boundary).
REQ-038 m0 requesting continuously, m1 asserts a read -> m1 granted within 2 cycles; m0_waitrequest=1 in that cycle.
REQ-039 Reset asserted in the cycle after an accepted read -> no readdatavalid; after release, last_grant=1 and m0 wins the next contention.

Source files
------------

// File: rtl/nios_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Reads return with a fixed one-cycle latency, tagged back to the issuing master.
module nios_ram_arbiter #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   // last_grant_r: 0 = m0 was granted last, 1 = m1 was granted last
   logic              last_grant_r;
   logic              tag_valid_r;
   logic              tag_owner_r;
   logic [ADDR_W-1:0] addr_hold_r;

   logic              req0_s;
   logic              req1_s;
   logic              gnt0_s;
   logic              gnt1_s;
   logic              gnt_any_s;
   logic              gnt_write_s;

   // Request decode and round-robin grant; nothing is granted while in reset
   always_comb begin
      req0_s = (m0_read | m0_write) & ~reset;
      req1_s = (m1_read | m1_write) & ~reset;
      if (req0_s && req1_s) begin
         gnt0_s = last_grant_r;
         gnt1_s = ~last_grant_r;
      end else begin
         gnt0_s = req0_s;
         gnt1_s = req1_s;
      end
      gnt_any_s = gnt0_s | gnt1_s;
   end

   // Wait-request generation: losers of contention stall, everyone stalls in reset
   always_comb begin
      if (reset) begin
         m0_waitrequest = 1'b1;
         m1_waitrequest = 1'b1;
      end else begin
         m0_waitrequest = req0_s & ~gnt0_s;
         m1_waitrequest = req1_s & ~gnt1_s;
      end
   end

   // RAM port mux; a read-and-write request is handled as a write
   always_comb begin
      if (gnt1_s) begin
         ram_address    = m1_address;
         ram_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
         ram_writedata  = m1_writedata;
         gnt_write_s    = m1_write;
      end else if (gnt0_s) begin
         ram_address    = m0_address;
         ram_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
         ram_writedata  = m0_writedata;
         gnt_write_s    = m0_write;
      end else begin
         ram_address    = addr_hold_r;
         ram_byteenable = {BE_W{1'b1}};
         ram_writedata  = {DATA_W{1'b0}};
         gnt_write_s    = 1'b0;
      end
      ram_chipselect = gnt_any_s;
      ram_write      = gnt_write_s;
      ram_clken      = ~reset;
   end

   // Grant history, read-return tag and idle address hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= 1'b1;
         tag_valid_r  <= 1'b0;
         tag_owner_r  <= 1'b0;
         addr_hold_r  <= {ADDR_W{1'b0}};
      end else begin
         tag_valid_r <= gnt_any_s & ~gnt_write_s;
         tag_owner_r <= gnt1_s;
         if (gnt_any_s) begin
            last_grant_r <= gnt1_s;
            addr_hold_r  <= ram_address;
         end else begin
            last_grant_r <= last_grant_r;
            addr_hold_r  <= addr_hold_r;
         end
      end
   end

   // Read data is shared; only the valid strobe identifies the owner
   always_comb begin
      m0_readdata      = ram_readdata;
      m1_readdata      = ram_readdata;
      m0_readdatavalid = tag_valid_r & ~tag_owner_r;
      m1_readdatavalid = tag_valid_r & tag_owner_r;
   end

endmodule

// File: tb/tb_nios_ram_arbiter.sv
// Bench for nios_ram_arbiter: synchronous RAM behind the arbiter, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_nios_ram_arbiter;

   logic        clk;
   logic        reset;
   logic [10:0] m0_address, m1_address, ram_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
   logic [31:0] m0_writedata, m1_writedata, ram_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata, ram_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        ram_chipselect, ram_write, ram_clken;

   int errors = 0;
   int checks = 0;

   nios_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Synchronous RAM attached to the arbiter's RAM port
   logic [31:0] ram_mem [0:2047];
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write)
            ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
         ram_readdata <= ram_mem[ram_address];
      end
   end

   // Reference model: who owns the RAM this cycle, and what should come back next cycle
   int          exp_last;
   bit          pend_valid;
   int          pend_owner;
   logic [31:0] pend_data;
   bit          addr_known;
   logic [10:0] last_addr;
   logic [31:0] shadow [0:2047];

   initial begin
      for (int i = 0; i < 2048; i++) begin
         ram_mem[i] = 32'h0;
         shadow[i]  = 32'h0;
      end
   end

   function automatic int model_grant();
      bit r0, r1;
      r0 = m0_read || m0_write;
      r1 = m1_read || m1_write;
      if (reset) return -1;
      if (r0 && r1) return (exp_last == 1) ? 0 : 1;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   function automatic logic [10:0] g_addr(input int g);
      return (g == 0) ? m0_address : m1_address;
   endfunction
   function automatic bit g_write(input int g);
      return (g == 0) ? m0_write : (g == 1) ? m1_write : 1'b0;
   endfunction
   function automatic logic [3:0] g_be(input int g);
      return (g == 0) ? m0_byteenable : m1_byteenable;
   endfunction
   function automatic logic [31:0] g_wd(input int g);
      return (g == 0) ? m0_writedata : m1_writedata;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_last   <= 1;
         pend_valid <= 1'b0;
         addr_known <= 1'b0;
      end else begin
         pend_valid <= (model_grant() >= 0) && !g_write(model_grant());
         if (model_grant() >= 0) begin
            exp_last   <= model_grant();
            last_addr  <= g_addr(model_grant());
            addr_known <= 1'b1;
            pend_owner <= model_grant();
            pend_data  <= shadow[g_addr(model_grant())];
            if (g_write(model_grant()))
               shadow[g_addr(model_grant())] <= merge(shadow[g_addr(model_grant())],
                                                      g_wd(model_grant()), g_be(model_grant()));
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (reset) begin
         chk("m_rst_m0_wait", 32'(m0_waitrequest), 32'd1);
         chk("m_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
         chk("m_rst_cs", 32'(ram_chipselect), 32'd0);
         chk("m_rst_write", 32'(ram_write), 32'd0);
         chk("m_rst_clken", 32'(ram_clken), 32'd0);
         chk("m_rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      end else begin
         chk("m_m0_wait", 32'(m0_waitrequest), 32'((m0_read || m0_write) && model_grant() != 0));
         chk("m_m1_wait", 32'(m1_waitrequest), 32'((m1_read || m1_write) && model_grant() != 1));
         chk("m_cs", 32'(ram_chipselect), 32'(model_grant() >= 0));
         chk("m_write", 32'(ram_write), 32'(g_write(model_grant())));
         chk("m_clken", 32'(ram_clken), 32'd1);
         if (model_grant() >= 0) begin
            chk("m_addr", 32'(ram_address), 32'(g_addr(model_grant())));
            chk("m_be", 32'(ram_byteenable),
                32'(g_write(model_grant()) ? g_be(model_grant()) : 4'hF));
            if (g_write(model_grant()))
               chk("m_wdata", ram_writedata, g_wd(model_grant()));
         end else if (addr_known) begin
            chk("m_addr_hold", 32'(ram_address), 32'(last_addr));
         end
         chk("m_m0_rdv", 32'(m0_readdatavalid), 32'(pend_valid && pend_owner == 0));
         chk("m_m1_rdv", 32'(m1_readdatavalid), 32'(pend_valid && pend_owner == 1));
         if (pend_valid) begin
            chk("m_m0_rdata", m0_readdata, pend_data);
            chk("m_m1_rdata", m1_readdata, pend_data);
         end
      end
   end

   task automatic idle();
      m0_read = 1'b0; m0_write = 1'b0; m0_address = 11'h0; m0_byteenable = 4'h0;
      m0_writedata = 32'h0;
      m1_read = 1'b0; m1_write = 1'b0; m1_address = 11'h0; m1_byteenable = 4'h0;
      m1_writedata = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      step();
      reset = 1'b1;
      idle();
      smp();
      chk("prst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("prst_m1_wait", 32'(m1_waitrequest), 32'd1);
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      smp();
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_clken", 32'(ram_clken), 32'd0);
      chk("rst_cs", 32'(ram_chipselect), 32'd0);

      // Write then read back on m0, starting on the first edge after release
      step();
      reset = 1'b0;
      m0_write = 1'b1; m0_address = 11'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      smp();
      chk("wr_wait", 32'(m0_waitrequest), 32'd0);
      chk("wr_ramwrite", 32'(ram_write), 32'd1);
      step();
      m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'h0;
      smp();
      chk("rd_wait", 32'(m0_waitrequest), 32'd0);
      chk("rd_be", 32'(ram_byteenable), 32'h0000000F);
      step();
      idle();
      smp();
      chk("rd_rdv", 32'(m0_readdatavalid), 32'd1);
      chk("rd_data", m0_readdata, 32'hDEADBEEF);
      chk("rd_addr_hold", 32'(ram_address), 32'h005);

      // Read and write together is a write: lanes 0 and 2 only, no return
      step();
      m0_read = 1'b1; m0_write = 1'b1; m0_address = 11'h00A;
      m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'h5;
      smp();
      chk("rw_is_write", 32'(ram_write), 32'd1);
      chk("rw_be", 32'(ram_byteenable), 32'h00000005);
      step();
      idle();
      smp();
      chk("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);

      // Contention straight after reset alternates m0,m1,m0,m1 with no bubble
      pulse_reset();
      m0_read = 1'b1; m0_address = 11'h005;
      m1_read = 1'b1; m1_address = 11'h00A;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("rr_m0_wait", 32'(m0_waitrequest), 32'(i % 2));
         chk("rr_m1_wait", 32'(m1_waitrequest), 32'(1 - (i % 2)));
         if (i > 0) begin
            chk("rr_m0_rdv", 32'(m0_readdatavalid), 32'((i - 1) % 2 == 0));
            chk("rr_m1_rdv", 32'(m1_readdatavalid), 32'((i - 1) % 2 == 1));
         end
         step();
      end
      idle();
      smp();
      chk("rr_last_m1_rdv", 32'(m1_readdatavalid), 32'd1);
      chk("rr_last_m0_rdv", 32'(m0_readdatavalid), 32'd0);
      chk("rr_last_data", m1_readdata, 32'h00A500A5);

      // Partial write at the top address
      step();
      m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
      smp();
      chk("wrap_addr", 32'(ram_address), 32'h7FF);
      step();
      m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
      step();
      m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'h0;
      step();
      idle();
      smp();
      chk("wrap_rdv", 32'(m1_readdatavalid), 32'd1);
      chk("wrap_data", m1_readdata, 32'hFFFF5678);

      // m0 streams reads; m1 joins and must be served within two cycles
      step();
      m0_read = 1'b1; m0_address = 11'h001;
      step();
      step();
      m1_read = 1'b1; m1_address = 11'h7FF;
      found = 1'b0;
      for (int k = 0; k < 2; k++) begin
         smp();
         if (m1_waitrequest == 1'b0) begin
            found = 1'b1;
            chk("starve_m0_wait", 32'(m0_waitrequest), 32'd1);
            break;
         end
         step();
      end
      chk("starve_bound", 32'(found), 32'd1);
      step();
      m1_read = 1'b0;
      step();
      idle();
      smp();
      step();

      // Reset in the cycle after an accepted m0 read cancels the return
      m0_read = 1'b1; m0_address = 11'h005;
      step();
      reset = 1'b1;
      idle();
      smp();
      chk("rst_rd_m0_rdv", 32'(m0_readdatavalid), 32'd0);
      chk("rst_rd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
      step();
      reset = 1'b0;
      m0_read = 1'b1; m0_address = 11'h005;
      m1_read = 1'b1; m1_address = 11'h7FF;
      smp();
      chk("post_rst_m0_wait", 32'(m0_waitrequest), 32'd0);
      chk("post_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      step();
      idle();
      smp();
      chk("post_rst_rdv", 32'(m0_readdatavalid), 32'd1);
      chk("post_rst_data", m0_readdata, 32'hDEADBEEF);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
